// File: rtl/stereo_frame_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stereo_frame_arbiter
//
// Shares one CSI-2 TX packetiser between two free-running camera byte streams
// (cam0, cam1). The TX path is granted to one source for a whole frame. Frames
// from the other source that start while the path is busy are dropped and
// counted. Every frame is followed by a fixed LP gap. A watchdog forces a frame
// end if the granted source never ends its frame.
//
// Ports
//   byte_clk, reset_n        clock, asynchronous active-low reset
//   i_en[1:0]                per-source start enable (bit0 cam0, bit1 cam1)
//   s0_* / s1_*              frame start/end pulses, data valid, 16-bit data
//   o_fv_start, o_fv_end     frame markers to the TX
//   o_vc, o_wc, o_dt         virtual channel (= source index), word count, type
//   o_data_en, o_data        forwarded byte data, 1 cycle after the input
//   o_busy                   high while ACTIVE or in the post-frame GAP
//   o_timeout                1-cycle pulse when the watchdog ends a frame
//   o_drop0, o_drop1         saturating dropped-frame counters
//   o_frame_cnt              completed (non-timeout) frames, wrapping
// -----------------------------------------------------------------------------
module stereo_frame_arbiter #(
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4194304,
  parameter logic [15:0] WC             = 16'd2400,
  parameter logic [5:0]  DT             = 6'h24
) (
  input  logic        byte_clk,
  input  logic        reset_n,
  input  logic [1:0]  i_en,
  input  logic        s0_fv_start,
  input  logic        s0_fv_end,
  input  logic        s0_data_en,
  input  logic [15:0] s0_data,
  input  logic        s1_fv_start,
  input  logic        s1_fv_end,
  input  logic        s1_data_en,
  input  logic [15:0] s1_data,
  output logic        o_fv_start,
  output logic        o_fv_end,
  output logic [1:0]  o_vc,
  output logic [15:0] o_wc,
  output logic [5:0]  o_dt,
  output logic        o_data_en,
  output logic [15:0] o_data,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_drop0,
  output logic [7:0]  o_drop1,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  // gap_cnt counts down from GAP_CYCLES-1 to 0, so GAP lasts GAP_CYCLES cycles.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT_CYCLES);

  state_t           state;
  logic             grant;     // source owning the current frame
  logic             last_src;  // last granted source, loses the next tie
  logic [23:0]      wd_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic        start0, start1;
  logic        pick, pick_den;
  logic [15:0] pick_data;
  logic        g_end, g_den, other_start;
  logic [15:0] g_data;

  assign o_wc = WC;
  assign o_dt = DT;

  // Only starts are gated by i_en; a frame already granted runs to its end.
  assign start0 = s0_fv_start & i_en[0];
  assign start1 = s1_fv_start & i_en[1];

  // Source chosen in IDLE: a tie goes to the source that did not win last time.
  assign pick      = (start0 & start1) ? ~last_src : start1;
  assign pick_den  = pick ? s1_data_en : s0_data_en;
  assign pick_data = pick ? s1_data    : s0_data;

  // Signals of the source that currently owns the frame.
  assign g_end       = grant ? s1_fv_end  : s0_fv_end;
  assign g_den       = grant ? s1_data_en : s0_data_en;
  assign g_data      = grant ? s1_data    : s0_data;
  assign other_start = grant ? start0     : start1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // NOTE: every register here is plain state with no memory array, so the
  // whole block, counters included, is cleared by the asynchronous reset.
  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_src    <= 1'b1;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      o_fv_start  <= 1'b0;
      o_fv_end    <= 1'b0;
      o_vc        <= 2'd0;
      o_data_en   <= 1'b0;
      o_data      <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_drop0     <= '0;
      o_drop1     <= '0;
      o_frame_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; pulse outputs default low
      // here and are raised by the branch below only in the cycle they fire.
      o_fv_start <= 1'b0;
      o_fv_end   <= 1'b0;
      o_timeout  <= 1'b0;
      o_data_en  <= 1'b0;
      o_data     <= '0;

      case (state)
        IDLE: begin
          if (start0 | start1) begin
            state      <= ACTIVE;
            o_busy     <= 1'b1;
            grant      <= pick;
            last_src   <= pick;
            o_vc       <= {1'b0, pick};
            o_fv_start <= 1'b1;
            o_data_en  <= pick_den;
            o_data     <= pick_den ? pick_data : '0;
            wd_cnt     <= 24'd1;
            if (start0 & start1) begin
              if (pick) o_drop0 <= sat_inc(o_drop0);
              else      o_drop1 <= sat_inc(o_drop1);
            end
          end
        end

        ACTIVE: begin
          o_data_en <= g_den;
          o_data    <= g_den ? g_data : '0;
          if (other_start) begin
            if (grant) o_drop0 <= sat_inc(o_drop0);
            else       o_drop1 <= sat_inc(o_drop1);
          end
          // A real end wins over a coincident watchdog expiry.
          if (g_end || (wd_cnt == WD_LIMIT)) begin
            state    <= GAP;
            gap_cnt  <= GAP_LOAD;
            o_fv_end <= 1'b1;
            if (g_end) o_frame_cnt <= o_frame_cnt + 16'd1;
            else       o_timeout   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 24'd1;
          end
        end

        GAP: begin
          if (start0) o_drop0 <= sat_inc(o_drop0);
          if (start1) o_drop1 <= sat_inc(o_drop1);
          if (gap_cnt == '0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_frame_arbiter.sv
`timescale 1ns/1ps
// Testbench for stereo_frame_arbiter. Stimulus pushes the expected output
// event (with the cycle it must appear in) into a queue; a monitor on the
// falling edge pops and compares whenever the DUT shows an output event.
module tb_stereo_frame_arbiter;

  localparam int unsigned GAP     = 8;
  localparam int unsigned TIMEOUT = 1000;

  logic        byte_clk;
  logic        reset_n;
  logic [1:0]  i_en;
  logic        s0_fv_start, s0_fv_end, s0_data_en;
  logic [15:0] s0_data;
  logic        s1_fv_start, s1_fv_end, s1_data_en;
  logic [15:0] s1_data;
  logic        o_fv_start, o_fv_end, o_data_en, o_busy, o_timeout;
  logic [1:0]  o_vc;
  logic [15:0] o_wc, o_data, o_frame_cnt;
  logic [5:0]  o_dt;
  logic [7:0]  o_drop0, o_drop1;

  stereo_frame_arbiter #(
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT), .WC(16'd2400), .DT(6'h24)
  ) dut (
    .byte_clk(byte_clk), .reset_n(reset_n), .i_en(i_en),
    .s0_fv_start(s0_fv_start), .s0_fv_end(s0_fv_end),
    .s0_data_en(s0_data_en), .s0_data(s0_data),
    .s1_fv_start(s1_fv_start), .s1_fv_end(s1_fv_end),
    .s1_data_en(s1_data_en), .s1_data(s1_data),
    .o_fv_start(o_fv_start), .o_fv_end(o_fv_end), .o_vc(o_vc),
    .o_wc(o_wc), .o_dt(o_dt), .o_data_en(o_data_en), .o_data(o_data),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_drop0(o_drop0),
    .o_drop1(o_drop1), .o_frame_cnt(o_frame_cnt)
  );

  typedef struct packed {
    logic        fs;
    logic        fe;
    logic        to;
    logic        den;
    logic [1:0]  vc;
    logic [15:0] data;
    logic [31:0] cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc     = 0;

  initial byte_clk = 1'b0;
  always #5 byte_clk = ~byte_clk;
  always @(posedge byte_clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the expected queue.
  always @(negedge byte_clk) begin
    if (reset_n) begin
      if (!o_data_en) check("data_zero_without_en", 32'(o_data), 32'd0);
      if (o_fv_start | o_fv_end | o_timeout | o_data_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got fs=%b fe=%b to=%b den=%b vc=%0d data=0x%0h at cycle %0d, required none",
                   o_fv_start, o_fv_end, o_timeout, o_data_en, o_vc, o_data, cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_flags_vc", 32'({o_fv_start, o_fv_end, o_timeout, o_data_en, o_vc}),
                32'({e.fs, e.fe, e.to, e.den, e.vc}));
          check("event_data", 32'(o_data), 32'(e.data));
        end
      end
    end
  end

  // Expect an output event one cycle after the inputs currently set up.
  task automatic exp_ev(input logic fs, input logic fe, input logic to, input logic den,
                        input logic [1:0] vc, input logic [15:0] data);
    ev_t e;
    e.fs = fs; e.fe = fe; e.to = to; e.den = den; e.vc = vc; e.data = data;
    e.cyc = cyc + 32'd1;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    s0_fv_start = 1'b0; s0_fv_end = 1'b0; s0_data_en = 1'b0; s0_data = '0;
    s1_fv_start = 1'b0; s1_fv_end = 1'b0; s1_data_en = 1'b0; s1_data = '0;
  endtask

  task automatic tick();
    @(posedge byte_clk);
    #1;
    clear_inputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_data(input logic src, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      if (src) begin s1_data_en = 1'b1; s1_data = base + 16'(i); end
      else     begin s0_data_en = 1'b1; s0_data = base + 16'(i); end
      exp_ev(1'b0, 1'b0, 1'b0, 1'b1, {1'b0, src}, base + 16'(i));
      tick();
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    ticks(3);
    @(negedge byte_clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0;
    i_en    = 2'b00;
    clear_inputs();
    apply_reset();

    // Reset state
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_vc", 32'(o_vc), 32'd0);
    check("rst_wc", 32'(o_wc), 32'd2400);
    check("rst_dt", 32'(o_dt), 32'h24);
    check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("rst_drops", 32'({o_drop0, o_drop1}), 32'd0);

    // Single source cam0 frame, data on the start and end cycles too
    i_en = 2'b01;
    s0_fv_start = 1'b1; s0_data_en = 1'b1; s0_data = 16'hA000;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'hA000);
    tick();
    check("single_busy", 32'(o_busy), 32'd1);
    for (int ln = 0; ln < 3; ln++) begin
      send_data(1'b0, 10, 16'hA100 + 16'(ln * 16));
      ticks(2);
    end
    s0_fv_end = 1'b1; s0_data_en = 1'b1; s0_data = 16'hA3FF;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'hA3FF);
    tick();
    check("single_frame_cnt", 32'(o_frame_cnt), 32'd1);
    ticks(GAP - 1);
    check("gap_busy_last_cycle", 32'(o_busy), 32'd1);
    tick();
    check("gap_busy_released", 32'(o_busy), 32'd0);

    // Simultaneous start after reset: cam0 wins, then cam1 wins the next tie
    apply_reset();
    i_en = 2'b11;
    s0_fv_start = 1'b1; s1_fv_start = 1'b1;
    s0_data_en = 1'b1; s0_data = 16'h0A0A; s1_data_en = 1'b1; s1_data = 16'h0B0B;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0A0A);
    tick();
    check("tie1_drop1", 32'(o_drop1), 32'd1);
    check("tie1_drop0", 32'(o_drop0), 32'd0);
    s1_data_en = 1'b1; s1_data = 16'h0B0C;   // non-granted data is ignored
    tick();
    s0_fv_end = 1'b1;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    ticks(GAP);
    s0_fv_start = 1'b1; s1_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0000);
    tick();
    check("tie2_drop0", 32'(o_drop0), 32'd1);
    check("tie2_vc", 32'(o_vc), 32'd1);
    send_data(1'b1, 4, 16'hB000);
    s1_fv_end = 1'b1;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0000);
    tick();
    ticks(GAP);
    check("tie_frame_cnt", 32'(o_frame_cnt), 32'd2);

    // Overlap drops: during a cam0 frame, mid GAP and on the final GAP cycle
    s0_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    send_data(1'b0, 3, 16'hC000);
    s1_fv_start = 1'b1; s1_data_en = 1'b1; s1_data = 16'hDEAD;
    tick();
    check("overlap_active_drop1", 32'(o_drop1), 32'd2);
    send_data(1'b0, 2, 16'hC100);
    s0_fv_end = 1'b1;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    ticks(3);
    s1_fv_start = 1'b1;
    tick();
    check("overlap_gap_drop1", 32'(o_drop1), 32'd3);
    ticks(GAP - 5);
    s1_fv_start = 1'b1;                       // final GAP cycle
    tick();
    check("overlap_last_gap_drop1", 32'(o_drop1), 32'd4);
    check("overlap_last_gap_idle", 32'(o_busy), 32'd0);

    // Drop counter saturation
    s0_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    for (int i = 0; i < 300; i++) begin
      s1_fv_start = 1'b1;
      tick();
      if (i == 250) check("drop1_reaches_255", 32'(o_drop1), 32'd255);
    end
    check("drop1_saturated", 32'(o_drop1), 32'd255);
    s0_fv_end = 1'b1;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    ticks(GAP);
    check("sat_frame_cnt", 32'(o_frame_cnt), 32'd4);

    // Watchdog: no end, fv_end/timeout 1000 cycles after o_fv_start
    i_en = 2'b01;
    s0_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    ticks(TIMEOUT - 1);
    exp_ev(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000);
    tick();
    check("timeout_pulse", 32'(o_timeout), 32'd1);
    check("timeout_frame_cnt", 32'(o_frame_cnt), 32'd4);
    tick();
    check("timeout_pulse_width", 32'(o_timeout), 32'd0);
    ticks(GAP - 1);
    check("timeout_gap_done", 32'(o_busy), 32'd0);

    // fv_end coincident with watchdog expiry counts as a normal end
    s0_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    ticks(TIMEOUT - 1);
    s0_fv_end = 1'b1;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    check("coincide_no_timeout", 32'(o_timeout), 32'd0);
    check("coincide_frame_cnt", 32'(o_frame_cnt), 32'd5);
    ticks(GAP);

    // Enable masking
    i_en = 2'b10;
    s0_fv_start = 1'b1;
    tick();
    check("masked_start_idle", 32'(o_busy), 32'd0);
    check("masked_start_no_drop", 32'(o_drop0), 32'd1);
    s1_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0000);
    tick();
    send_data(1'b1, 3, 16'hE000);
    s0_fv_start = 1'b1;
    tick();
    check("masked_active_no_drop", 32'(o_drop0), 32'd1);
    i_en = 2'b00;
    send_data(1'b1, 3, 16'hE010);
    s1_fv_end = 1'b1;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0000);
    tick();
    check("disabled_frame_completes", 32'(o_frame_cnt), 32'd6);
    ticks(GAP);

    // Reset in the middle of a cam1 frame with data flowing
    i_en = 2'b11;
    s1_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0000);
    tick();
    send_data(1'b1, 2, 16'hF000);
    s1_data_en = 1'b1; s1_data = 16'hF0FF;
    exp_ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'hF0FF);
    @(posedge byte_clk);
    #1;
    @(negedge byte_clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_data_en", 32'(o_data_en), 32'd0);
    check("midrst_data", 32'(o_data), 32'd0);
    check("midrst_vc", 32'(o_vc), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_counters", 32'({o_drop0, o_drop1, o_frame_cnt}), 32'd0);
    check("midrst_wc_dt", 32'({o_wc, 10'd0, o_dt}), 32'({16'd2400, 10'd0, 6'h24}));
    clear_inputs();
    ticks(3);
    check("midrst_no_fv_end", 32'(o_fv_end), 32'd0);
    @(negedge byte_clk);
    reset_n = 1'b1;
    tick();
    i_en = 2'b01;
    s0_fv_start = 1'b1;
    exp_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    send_data(1'b0, 2, 16'h1234);
    s0_fv_end = 1'b1;
    exp_ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    tick();
    check("post_rst_frame_cnt", 32'(o_frame_cnt), 32'd1);
    ticks(GAP + 2);

    check("expected_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stereo_frame_arbiter.md
Name: stereo_frame_arbiter

Overview:
Frame-granular arbiter that shares the single CSI-2 TX packetiser between the two camera pixel-to-byte converter outputs (cam0, cam1) in the stereo camera design. The converters are free-running and cannot be stalled, so the block grants the TX path to one source for a whole frame and drops competing frames. Each source is tagged with its own virtual channel. The block also enforces an LP gap between frames and a watchdog on frames that never end.

Parameters:
GAP_CYCLES, 64, byte_clk cycles spent in GAP after every frame end (minimum 1).
TIMEOUT_CYCLES, 4194304, maximum ACTIVE length before a forced frame end (fits a 24-bit counter).
WC, 16'd2400, word count driven on o_wc.
DT, 6'h24, data type driven on o_dt (RGB888).

Ports:
byte_clk  in  1  byte clock; all logic is on this clock.
reset_n  in  1  asynchronous, active-low reset.
i_en  in  2  per-source enable: bit0 = cam0, bit1 = cam1.
s0_fv_start  in  1  cam0 frame-start pulse (1 cycle).
s0_fv_end  in  1  cam0 frame-end pulse (1 cycle).
s0_data_en  in  1  cam0 byte-data valid.
s0_data  in  16  cam0 two-lane byte data.
s1_fv_start, s1_fv_end, s1_data_en, s1_data  in  1/1/1/16  same signals for cam1.
o_fv_start  out  1  to CSI-2 TX I_FV_START.
o_fv_end  out  1  to CSI-2 TX I_FV_END.
o_vc  out  2  to I_VC; 0 = cam0, 1 = cam1.
o_wc  out  16  to I_WC; constant WC.
o_dt  out  6  to I_DT; constant DT.
o_data_en  out  1  to I_DATA_EN.
o_data  out  16  to I_DATA.
o_busy  out  1  high in ACTIVE or GAP.
o_timeout  out  1  1-cycle pulse when the watchdog fires.
o_drop0  out  8  saturating count of dropped cam0 frames.
o_drop1  out  8  saturating count of dropped cam1 frames.
o_frame_cnt  out  16  count of completed (non-timeout) frames; wraps.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE. last_src=1, so cam0 wins the first tie. All outputs 0 except o_wc=WC and o_dt=DT. Counters cleared. Reset mid-frame emits no o_fv_end.
- All outputs are registered. Latency from a granted source input to its output is exactly 1 cycle.
- The enabled start for cam n is sn_fv_start & i_en[n]. i_en is evaluated every cycle and never aborts the frame in progress.
- A disabled source's pulses are ignored and never counted as drops.

IDLE:
- One enabled start: grant that source, set o_vc to its index, pulse o_fv_start the next cycle, go to ACTIVE.
- Both enabled starts in the same cycle: grant the source != last_src and count the other as a drop. last_src is updated to the granted source.
- A granted source's data_en in the same cycle as its fv_start is forwarded.

ACTIVE:
- o_data_en and o_data follow the granted source delayed by 1 cycle. o_data=0 whenever o_data_en=0.
- Non-granted source: data is ignored. Its enabled fv_start increments its drop counter, saturating at 255.
- A repeated fv_start from the granted source is ignored; the frame continues.
- Granted fv_end: pulse o_fv_end next cycle, increment o_frame_cnt, go to GAP. A data_en in the same cycle is forwarded in the same output cycle as o_fv_end.
- Watchdog: counts cycles in ACTIVE starting at 1. When the count reaches TIMEOUT_CYCLES, pulse o_fv_end and o_timeout next cycle, go to GAP, o_frame_cnt unchanged.
- If fv_end and the timeout coincide, treat it as a normal end: no o_timeout, frame counted.

GAP:
- Stays exactly GAP_CYCLES cycles, then goes to IDLE.
- o_data_en=0.
- Any enabled fv_start during GAP, including the final GAP cycle, counts as a drop.
- fv_end pulses are ignored.

General:
- o_vc holds its value from o_fv_start through o_fv_end and until the next grant.
- o_busy is registered with the state.
- Data arriving in IDLE without a grant is discarded.

Test Plan:
- Single source: i_en=01, cam0 frame with start, 600 lines of 1200 data_en cycles, end. Expect o_fv_start 1 cycle after start, o_vc=0, 720000 o_data_en cycles identical to input delayed 1, o_fv_end 1 cycle after end, o_frame_cnt=1, o_busy low GAP_CYCLES+1 cycles after end.
- Simultaneous start: i_en=11, both fv_start together after reset. Expect cam0 granted, o_drop1=1; repeat after GAP and expect cam1 granted (o_vc=1), o_drop0=1.
- Overlap drop: cam1 fv_start during a cam0 frame and during GAP. Expect o_drop1 incremented twice, no output disturbance; 300 such starts leave o_drop1=255.
- Timeout: TIMEOUT_CYCLES=1000, start with no end. Expect o_fv_end and o_timeout at cycle 1000 after grant, o_frame_cnt unchanged; coincident fv_end at 1000 gives no o_timeout.
- Enable masking: i_en=10, cam0 starts ignored with o_drop0=0; clear i_en mid cam1 frame and expect the frame to complete normally.
- Reset mid-frame: deassert reset_n during ACTIVE. Expect all outputs 0 asynchronously, no o_fv_end; the next cam0 start is granted normally.
